// File: rtl/mp3dec_i2s_tx.sv
// Philips I2S transmitter for the MP3 decoder PCM path.
// Pops one {left,right} word per 32-SCK frame from the output FIFO and
// shifts it out MSB first with WS leading the data by one bit clock.
// SCK is a divided-down HCLK; an empty FIFO at frame start sends silence
// and bumps a saturating underrun counter.
module mp3dec_i2s_tx #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             enable,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             pcm_valid,
   input  logic [31:0]      pcm_data,
   output logic             pcm_ready,
   output logic             i2s_sck,
   output logic             i2s_ws,
   output logic             i2s_sd,
   output logic             busy,
   output logic             underrun,
   output logic [CNT_W-1:0] underrun_cnt,
   input  logic             underrun_clr
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] div_cnt;
   logic             start;
   logic [4:0]       slot;
   logic [31:0]      frame;

   logic [DIV_W-1:0] cnt_n;
   logic             sck_n;
   logic [4:0]       slot_n;
   logic             tick;
   logic             fall;
   logic             stop;
   logic             ready_n;
   logic             udr;

   // Divider/slot next-state and event decode. The first RUN cycle holds the
   // divider so that it plays the same role as a frame-ending falling edge,
   // which keeps every frame (including the first) exactly 64*(D+1) cycles.
   // pcm_ready is predicted one cycle early so it is a plain register; a
   // frame end without a predicted pop is the stop point.
   always_comb begin
      tick    = (state == RUN) && !start && (div_cnt == div_r);
      fall    = tick && i2s_sck;
      stop    = fall && (slot == 5'd31) && !pcm_ready;
      udr     = pcm_ready && !pcm_valid;
      cnt_n   = div_cnt;
      if (tick)
         cnt_n = '0;
      else if ((state == RUN) && !start)
         cnt_n = div_cnt + DIV_W'(1);
      sck_n   = tick ? ~i2s_sck : i2s_sck;
      slot_n  = fall ? slot + 5'd1 : slot;
      ready_n = (state == RUN) && !stop && enable && (cnt_n == div_r) &&
                sck_n && (slot_n == 5'd31);
   end

   // Main sequencer: IDLE/RUN control, divider, slot counter and serial outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         div_r     <= '0;
         div_cnt   <= '0;
         start     <= 1'b0;
         slot      <= '0;
         frame     <= '0;
         pcm_ready <= 1'b0;
         i2s_sck   <= 1'b0;
         i2s_ws    <= 1'b0;
         i2s_sd    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state     <= RUN;
                  div_r     <= clk_div;
                  div_cnt   <= '0;
                  slot      <= '0;
                  start     <= 1'b1;
                  pcm_ready <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state     <= IDLE;
                  div_cnt   <= '0;
                  slot      <= '0;
                  start     <= 1'b0;
                  pcm_ready <= 1'b0;
                  i2s_sck   <= 1'b0;
                  i2s_ws    <= 1'b0;
                  i2s_sd    <= 1'b0;
               end else begin
                  start     <= 1'b0;
                  div_cnt   <= cnt_n;
                  i2s_sck   <= sck_n;
                  slot      <= slot_n;
                  pcm_ready <= ready_n;
                  if (pcm_ready) begin
                     // Load event: take the FIFO word or fall back to silence.
                     frame  <= pcm_valid ? pcm_data : 32'd0;
                     i2s_sd <= pcm_valid ? pcm_data[31] : 1'b0;
                     i2s_ws <= 1'b0;
                  end else if (fall) begin
                     // 31-slot is the bitwise inverse of a 5-bit slot index.
                     i2s_sd <= frame[~slot_n];
                     i2s_ws <= (slot_n >= 5'd15) && (slot_n != 5'd31);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Underrun pulse and saturating counter; a clear that lands on an
   // underrun still records that underrun.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         underrun <= udr;
         if (underrun_clr)
            underrun_cnt <= udr ? CNT_W'(1) : '0;
         else if (udr && !(&underrun_cnt))
            underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_mp3dec_i2s_tx.sv
// Bench for mp3dec_i2s_tx: a timing-formula reference model checks every
// output every cycle, plus directed checks of the frame-level behaviour.
module tb_mp3dec_i2s_tx;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  clk_div = 8'd1;
   logic        pcm_valid = 1'b0;
   logic [31:0] pcm_data = 32'd0;
   logic        underrun_clr = 1'b0;
   logic        pcm_ready, i2s_sck, i2s_ws, i2s_sd, busy, underrun;
   logic [15:0] underrun_cnt;

   mp3dec_i2s_tx #(.DIV_W(8), .CNT_W(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable), .clk_div(clk_div),
      .pcm_valid(pcm_valid), .pcm_data(pcm_data), .pcm_ready(pcm_ready),
      .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .busy(busy),
      .underrun(underrun), .underrun_cnt(underrun_cnt),
      .underrun_clr(underrun_clr)
   );

   always #5 HCLK = ~HCLK;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic chk_on = 1'b0;
   logic rnd_data = 1'b0, rnd_valid = 1'b0, rnd_clr = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge HCLK) cyc <= cyc + 1;

   // Background random drivers.
   always @(posedge HCLK) begin
      #1;
      if (rnd_data)  pcm_data = $urandom;
      if (rnd_valid) pcm_valid = ($urandom_range(0, 3) != 0);
      if (rnd_clr)   underrun_clr = ($urandom_range(0, 40) == 0);
   end

   // I2S receiver-style monitor: shifts SD/WS in on each SCK rise.
   logic [31:0] sh = 0, wsh = 0;
   logic prev_sck = 0;
   int last_rise = 0, sck_per = 0, xfers = 0, rdy_seen = 0;
   always @(negedge HCLK) begin
      if (i2s_sck && !prev_sck) begin
         sh = {sh[30:0], i2s_sd};
         wsh = {wsh[30:0], i2s_ws};
         sck_per = cyc - last_rise;
         last_rise = cyc;
      end
      prev_sck = i2s_sck;
      if (pcm_ready && pcm_valid) xfers++;
      if (pcm_ready) rdy_seen++;
   end

   // Reference model: position in the run (t) determines every output by
   // plain arithmetic on the slot/half-period lengths.
   logic        m_run = 0, m_prev_en = 0, m_udr = 0;
   int          m_t = 0, m_D = 0;
   logic [31:0] m_frame = 0;
   logic [15:0] m_cnt = 0;
   always @(negedge HCLK) begin
      int P, u, s;
      logic e_rdy, e_sck, e_ws, e_sd, e_busy, udr;
      e_rdy = 0; e_sck = 0; e_ws = 0; e_sd = 0; e_busy = 0;
      P = 64 * (m_D + 1);
      if (!HRESETn) begin
         m_run = 0; m_t = 0; m_prev_en = 0; m_udr = 0; m_cnt = 0; m_frame = 0;
      end else if (m_run) begin
         e_busy = 1;
         if (m_t == 0) e_rdy = 1;
         else begin
            u = m_t - 1;
            s = (u / (2 * (m_D + 1))) % 32;
            e_sck = ((u / (m_D + 1)) % 2) == 1;
            e_sd = m_frame[31 - s];
            e_ws = (s >= 15) && (s <= 30);
            e_rdy = ((m_t % P) == 0) && m_prev_en;
         end
      end
      if (chk_on) begin
         check("busy", busy, e_busy);
         check("pcm_ready", pcm_ready, e_rdy);
         check("sck", i2s_sck, e_sck);
         check("ws", i2s_ws, e_ws);
         check("sd", i2s_sd, e_sd);
         check("underrun", underrun, m_udr);
         check("underrun_cnt", underrun_cnt, m_cnt);
      end
      if (HRESETn) begin
         udr = e_rdy && !pcm_valid;
         if (e_rdy) m_frame = pcm_valid ? pcm_data : 32'd0;
         if (underrun_clr) m_cnt = udr ? 16'd1 : 16'd0;
         else if (udr && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_udr = udr;
         if (!m_run) begin
            if (enable) begin m_run = 1; m_t = 0; m_D = int'(clk_div); end
         end else if (m_t > 0 && (m_t % P) == 0 && !m_prev_en) m_run = 0;
         else m_t++;
         m_prev_en = enable;
      end
   end

   task automatic wait_rdy(input string tag, output int stamp);
      int n = 0;
      stamp = -1;
      while (n < 2000) begin
         @(negedge HCLK); #1;
         n++;
         if (pcm_ready) begin stamp = cyc; break; end
      end
      if (stamp < 0) begin
         total++; bad++;
         $display("FAIL %s: pcm_ready not seen within 2000 cycles", tag);
      end
   endtask

   task automatic wait_idle(input string tag, output int stamp);
      int n = 0;
      stamp = -1;
      while (n < 2000) begin
         @(negedge HCLK); #1;
         n++;
         if (!busy) begin stamp = cyc; break; end
      end
      if (stamp < 0) begin
         total++; bad++;
         $display("FAIL %s: busy stuck high for 2000 cycles", tag);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   initial begin
      int c0, c1, c2, x0, r0;
      #2 HRESETn = 1'b0;
      #1 chk_on = 1'b1;
      cycles(3);
      HRESETn = 1'b1;
      cycles(2);

      // 1: fixed word, clk_div=1
      clk_div = 8'd1; pcm_valid = 1'b1; pcm_data = 32'hA5A5_3C3C; enable = 1'b1;
      wait_rdy("t1_rdy0", c0);
      wait_rdy("t1_rdy1", c1);
      check("t1_period", c1 - c0, 128);
      check("t1_sd_word", sh, 32'hA5A5_3C3C);
      check("t1_ws_word", wsh, 32'h0001_FFFE);
      check("t1_sck_per", sck_per, 4);

      // 2: underruns at clk_div=0, clear coincident with an underrun
      cycles(1); enable = 1'b0;
      wait_idle("t1_stop", c2);
      cycles(1); clk_div = 8'd0; pcm_valid = 1'b0; enable = 1'b1;
      wait_rdy("t2_rdy0", c0);
      wait_rdy("t2_rdy1", c1);
      check("t2_period", c1 - c0, 64);
      wait_rdy("t2_rdy2", c1);
      check("t2_sd_silence", sh, 32'd0);
      @(negedge HCLK); #1;
      check("t2_cnt3", underrun_cnt, 16'd3);
      cycles(63); underrun_clr = 1'b1;
      @(negedge HCLK); #1;
      check("t2_rdy4", pcm_ready, 1'b1);
      cycles(1); underrun_clr = 1'b0;
      @(negedge HCLK); #1;
      check("t2_clr_cnt", underrun_cnt, 16'd1);

      // 3: two back-to-back frames
      enable = 1'b0;
      wait_idle("t2_stop", c2);
      cycles(1);
      x0 = xfers; pcm_valid = 1'b1; pcm_data = 32'h7FFF_8000; enable = 1'b1;
      wait_rdy("t3_rdy0", c0);
      cycles(1); pcm_data = 32'h0001_FFFF;
      wait_rdy("t3_rdy1", c1);
      check("t3_gapless", c1 - c0, 64);
      check("t3_frame1", sh, 32'h7FFF_8000);
      cycles(1); pcm_valid = 1'b0; enable = 1'b0;
      wait_idle("t3_stop", c2);
      check("t3_frame2", sh, 32'h0001_FFFF);
      check("t3_xfers", xfers - x0, 2);

      // 4: stop requested at slot 5
      cycles(1); rnd_data = 1'b1; pcm_valid = 1'b1; enable = 1'b1;
      wait_rdy("t4_rdy0", c0);
      wait_rdy("t4_rdy1", c0);
      cycles(11); enable = 1'b0;
      wait_idle("t4_stop", c2);
      check("t4_stop_time", c2 - c0, 65);
      check("t4_idle_pins", {i2s_sck, i2s_ws, i2s_sd}, 3'b000);
      r0 = rdy_seen;
      cycles(100);
      check("t4_no_pop", rdy_seen - r0, 0);

      // 5: clk_div change ignored until restart
      clk_div = 8'd1; enable = 1'b1;
      wait_rdy("t5_rdy0", c0);
      cycles(1); clk_div = 8'd3;
      wait_rdy("t5_rdy1", c1);
      check("t5_period_old", c1 - c0, 128);
      check("t5_sck_old", sck_per, 4);
      cycles(1); enable = 1'b0;
      wait_idle("t5_stop", c2);
      cycles(1); enable = 1'b1;
      wait_rdy("t5_rdy2", c0);
      wait_rdy("t5_rdy3", c1);
      check("t5_period_new", c1 - c0, 256);
      check("t5_sck_new", sck_per, 8);

      // 6: reset at slot 20
      cycles(1); enable = 1'b0;
      wait_idle("t5_stop2", c2);
      cycles(1); clk_div = 8'd1; rnd_valid = 1'b1; enable = 1'b1;
      wait_rdy("t6_rdy0", c0);
      wait_rdy("t6_rdy1", c0);
      cycles(81); HRESETn = 1'b0;
      #1;
      check("t6_rst_pins", {pcm_ready, i2s_sck, i2s_ws, i2s_sd, busy, underrun}, 6'd0);
      check("t6_rst_cnt", underrun_cnt, 16'd0);
      cycles(2); HRESETn = 1'b1;
      @(negedge HCLK); #1;
      check("t6_idle_after_rst", busy, 1'b0);
      @(negedge HCLK); #1;
      check("t6_fresh_load", {busy, pcm_ready}, 2'b11);

      // 7: randomized operation
      rnd_clr = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycles($urandom_range(50, 400));
         if ($urandom_range(0, 1) == 1) begin
            enable = 1'b0;
            cycles($urandom_range(1, 80));
            if ($urandom_range(0, 2) == 0) clk_div = 8'($urandom_range(0, 2));
            enable = 1'b1;
         end
      end
      rnd_clr = 1'b0; rnd_valid = 1'b0; rnd_data = 1'b0;
      cycles(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mp3dec_i2s_tx.md
Name: mp3dec_i2s_tx

Overview:
PCM output stage directly downstream of the MP3 decoder output FIFO, clocked in the HCLK domain. It pops one 32-bit stereo word per frame ({left[15:0], right[15:0]}) over a valid/ready handshake and serialises it as Philips I2S. SCK is derived from HCLK by a programmable divider. Underruns emit silence and are counted for interrupt and status logic.

Parameters:
DIV_W, 8, width of the SCK half-period divider setting
CNT_W, 16, width of the saturating underrun counter

Ports:
HCLK  input  1  system clock; the only clock in the block
HRESETn  input  1  asynchronous, active-low reset
enable  input  1  start/stop request, level sensitive
clk_div  input  DIV_W  SCK half-period = clk_div+1 HCLK cycles
pcm_valid  input  1  output-FIFO word available
pcm_data  input  32  [31:16] left, [15:0] right, two's complement
pcm_ready  output  1  one-cycle pop strobe; transfer when pcm_valid && pcm_ready
i2s_sck  output  1  bit clock
i2s_ws  output  1  word select: 0 = left, 1 = right
i2s_sd  output  1  serial data, MSB first
busy  output  1  high in RUN state
underrun  output  1  one-cycle pulse when a frame is loaded with no data
underrun_cnt  output  CNT_W  saturating underrun count
underrun_clr  input  1  synchronous clear of underrun_cnt

Behaviour:
- Clocking and reset: single clock HCLK. Reset is asynchronous, active-low (HRESETn).
- Reset values: every output is 0, state is IDLE, and all internal counters and registers are 0.
- States:
  - IDLE: sck=ws=sd=0, pcm_ready=0.
  - RUN: serialising.
- IDLE->RUN: on the first cycle enable=1 in IDLE.
  - clk_div is latched into div_r at this transition. clk_div changes are ignored while in RUN.
  - The first RUN cycle is a load event. The divider count starts at 0 and sck=0.
- Divider:
  - div_cnt counts 0..div_r. At div_r it wraps to 0 and sck toggles.
  - div_r=0 gives SCK = HCLK/2.
- Falling edge: the HCLK cycle in which sck toggles 1->0. This edge advances slot s (0..31, wraps 31->0). Rising edges have no other effect.
- Load event: the first RUN cycle, plus every falling edge where s wraps 31->0.
  - pcm_ready=1 for exactly that cycle. It is registered-state derived and does not depend on pcm_valid.
  - If pcm_valid=1: frame <= pcm_data.
  - If pcm_valid=0: frame <= 0, underrun pulses, and underrun_cnt increments (saturating at all-ones).
- Outputs are registered and updated only on load or falling-edge cycles:
  - sd = frame[31-s].
  - ws = 1 for s in 15..30, 0 for s in 31 and 0..14. WS therefore leads the data MSB by one SCK (I2S one-bit delay).
- Frame length: 32 SCK. With div_r=D, the frame takes 64*(D+1) HCLK cycles and pcm_ready pulses with exactly that period.
- Stop:
  - enable=0 in RUN does not truncate the frame.
  - At the next would-be load event (s=31 falling edge), go to IDLE instead: no pcm_ready, no underrun, sck/ws/sd return to 0 in that cycle.
  - If enable returns to 1 before that edge, RUN continues uninterrupted.
- underrun_clr:
  - Sets underrun_cnt to 0.
  - If it coincides with an underrun, the count becomes 1.
- Reset mid-frame: immediate return to the reset state. The partially sent frame is lost and no pop occurs.
- pcm_data is sampled only in a cycle where pcm_valid && pcm_ready.

Test Plan:
1. Reset, clk_div=1, pcm_valid=1, pcm_data=0xA5A5_3C3C, enable=1 -> pcm_ready pulses at RUN entry and every 128 HCLK. SD over slots 0..31 = A5A53C3C MSB first. WS low for slots 31,0..14 and high for 15..30. SCK period 4 HCLK.
2. clk_div=0, pcm_valid held 0 -> frames of all-zero SD, underrun pulse every 64 HCLK, underrun_cnt=3 after 3 loads. underrun_clr coincident with a 4th underrun -> cnt=1.
3. Stream 0x7FFF_8000 then 0x0001_FFFF back-to-back -> the two frames are contiguous with no gap slot, and exactly two pcm_ready&&valid transfers.
4. Deassert enable at slot 5 of a frame -> remaining slots are sent, then IDLE at the s=31->0 edge with sck=ws=sd=0, no further pcm_ready, busy=0.
5. Change clk_div 1->3 mid-run -> SCK period remains 4 HCLK until stop/restart, then 8 HCLK.
6. Assert HRESETn=0 at slot 20 -> all outputs 0 immediately. After release with enable=1, a fresh load occurs on the first RUN cycle.
